intp_ctrl_vec: RTL and testbench

Vectored, prioritised interrupt controller for SIG_NUM sources. Each source has its own edge/level and polarity capture, software set/clear, mask and priority. It arbitrates the pending, unmasked sources above a priority threshold and presents one winner to the CPU-side interface through a req/ack/eoi handshake. It sits between peripheral interrupt lines and the core, and replaces single-output aggregation where the handler needs a source ID.

---
 rtl/intp_ctrl_vec.sv | 224 ++++++++++++++++++++++
 tb/tb_intp_ctrl_vec.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/intp_ctrl_vec.sv
// ---------------------------------------------------------------------------
// intp_ctrl_vec -- vectored, prioritised interrupt controller.
//
// Each source has edge/level and polarity capture, software set/clear, a mask
// and a priority. Pending, unmasked sources with a priority above prio_thresh
// compete. The highest priority wins, and ties go to the lowest index. The
// winner is presented to the core through a req/ack/eoi handshake.
//
// Optional build macro:
//   INTP_SYNC_EN -- passes each intp_sig bit through a 2-flop synchroniser
//                   before capture. This adds 2 cycles of latency.
//
// Ports:
//   clk, rst_n      clock; asynchronous active-low reset
//   intp_sig        raw source lines
//   intp_sig_set    software set of pending bit (pulse)
//   intp_sig_clr    software clear of pending bit (pulse, wins over set)
//   intp_sig_mode   0 = edge, 1 = level
//   intp_sig_polar  0 = falling/low, 1 = rising/high
//   intp_sig_mask   1 = source masked
//   intp_sig_prio   per-source priority, source i at [i*PRIO_W +: PRIO_W]
//   prio_thresh     only prio > prio_thresh is eligible
//   irq_ack         core accepts presented request (REQ only)
//   irq_eoi         core finished servicing (BUSY only)
//   intp_sig_stat   registered pending bits
//   intp_sig_out    OR of unmasked pending bits
//   irq_req         request valid
//   irq_id          winning source index
//   irq_prio        priority of irq_id
//   irq_busy        request acknowledged, awaiting eoi
// ---------------------------------------------------------------------------

// Per-source capture and pending bit.
module intp_ctrl_vec_lane (
   input  logic clk,
   input  logic rst_n,
   input  logic sig_i,
   input  logic set_i,
   input  logic clr_i,
   input  logic mode_i,
   input  logic polar_i,
   input  logic ack_clr_i,
   output logic stat_o
);

   logic s, s_dly_q, stat_q, stat_d;
   logic rise, fall, det;

`ifdef INTP_SYNC_EN
   logic [1:0] sync_q;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) sync_q <= '0;
      else        sync_q <= {sync_q[0], sig_i};
   end
   assign s = sync_q[1];
`else
   assign s = sig_i;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) s_dly_q <= 1'b0;
      else        s_dly_q <= s;
   end

   assign rise = s & ~s_dly_q;
   assign fall = ~s & s_dly_q;
   // Level sources look at the delayed sample. A source that stays active
   // therefore re-pends in the cycle after an ack-clear.
   assign det  = mode_i ? (s_dly_q == polar_i) : (polar_i ? rise : fall);

   always_comb begin
      stat_d = stat_q;
      if (clr_i)               stat_d = 1'b0;
      else if (ack_clr_i)      stat_d = 1'b0;  // a coincident edge is lost
      else if (set_i || det)   stat_d = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) stat_q <= 1'b0;
      else        stat_q <= stat_d;
   end

   assign stat_o = stat_q;

endmodule

module intp_ctrl_vec #(
   parameter int SIG_NUM = 8,
   parameter int ID_W    = 3,
   parameter int PRIO_W  = 2
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [SIG_NUM-1:0]        intp_sig,
   input  logic [SIG_NUM-1:0]        intp_sig_set,
   input  logic [SIG_NUM-1:0]        intp_sig_clr,
   input  logic [SIG_NUM-1:0]        intp_sig_mode,
   input  logic [SIG_NUM-1:0]        intp_sig_polar,
   input  logic [SIG_NUM-1:0]        intp_sig_mask,
   input  logic [SIG_NUM*PRIO_W-1:0] intp_sig_prio,
   input  logic [PRIO_W-1:0]         prio_thresh,
   input  logic                      irq_ack,
   input  logic                      irq_eoi,
   output logic [SIG_NUM-1:0]        intp_sig_stat,
   output logic                      intp_sig_out,
   output logic                      irq_req,
   output logic [ID_W-1:0]           irq_id,
   output logic [PRIO_W-1:0]         irq_prio,
   output logic                      irq_busy
);

   localparam int ID_N = 2**ID_W;

   typedef enum logic [1:0] {IDLE, REQ, BUSY} state_e;

   state_e              state_q;
   logic                irq_req_q, irq_busy_q;
   logic [ID_W-1:0]     id_q;
   logic [PRIO_W-1:0]   prio_q;

   logic [SIG_NUM-1:0]  stat, elig, ack_clr;
   logic [ID_N-1:0]     elig_pad;
   logic                any_elig, ack_hit;
   logic [ID_W-1:0]     win_id;
   logic [PRIO_W-1:0]   win_prio;

   // Capture lanes
   for (genvar i = 0; i < SIG_NUM; i++) begin : g_lane
      intp_ctrl_vec_lane u_lane (
         .clk       (clk),
         .rst_n     (rst_n),
         .sig_i     (intp_sig[i]),
         .set_i     (intp_sig_set[i]),
         .clr_i     (intp_sig_clr[i]),
         .mode_i    (intp_sig_mode[i]),
         .polar_i   (intp_sig_polar[i]),
         .ack_clr_i (ack_clr[i]),
         .stat_o    (stat[i])
      );
   end

   // Eligibility and arbitration. A descending scan with >= lets the lower
   // index take a tie.
   always_comb begin
      elig     = '0;
      any_elig = 1'b0;
      win_id   = '0;
      win_prio = '0;
      for (int i = 0; i < SIG_NUM; i++)
         elig[i] = stat[i] & ~intp_sig_mask[i] &
                   (intp_sig_prio[i*PRIO_W +: PRIO_W] > prio_thresh);
      for (int i = SIG_NUM-1; i >= 0; i--) begin
         if (elig[i] && (!any_elig || intp_sig_prio[i*PRIO_W +: PRIO_W] >= win_prio)) begin
            any_elig = 1'b1;
            win_id   = ID_W'(i);
            win_prio = intp_sig_prio[i*PRIO_W +: PRIO_W];
         end
      end
   end

   // The vector is padded to 2^ID_W, so id_q always indexes in range.
   always_comb begin
      elig_pad             = '0;
      elig_pad[SIG_NUM-1:0] = elig;
   end

   // The ack is taken only while the latched source is still eligible.
   // Otherwise the request is being withdrawn in the same cycle.
   assign ack_hit = (state_q == REQ) && irq_ack && elig_pad[id_q];

   always_comb begin
      ack_clr = '0;
      for (int i = 0; i < SIG_NUM; i++)
         ack_clr[i] = ack_hit && (id_q == ID_W'(i));
   end

   // Handshake FSM with registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         irq_req_q  <= 1'b0;
         irq_busy_q <= 1'b0;
         id_q       <= '0;
         prio_q     <= '0;
      end else begin
         case (state_q)
            IDLE: if (any_elig) begin
               id_q      <= win_id;
               prio_q    <= win_prio;
               irq_req_q <= 1'b1;
               state_q   <= REQ;
            end
            // A presented request is never replaced by a later, higher-priority
            // arrival. It is only withdrawn when its own source is no longer
            // eligible.
            REQ: if (!elig_pad[id_q]) begin
               irq_req_q <= 1'b0;
               state_q   <= IDLE;
            end else if (irq_ack) begin
               irq_req_q  <= 1'b0;
               irq_busy_q <= 1'b1;
               state_q    <= BUSY;
            end
            BUSY: if (irq_eoi) begin
               irq_busy_q <= 1'b0;
               state_q    <= IDLE;
            end
            default: begin
               irq_req_q  <= 1'b0;
               irq_busy_q <= 1'b0;
               state_q    <= IDLE;
            end
         endcase
      end
   end

   assign intp_sig_stat = stat;
   assign intp_sig_out  = |(~intp_sig_mask & stat);
   assign irq_req       = irq_req_q;
   assign irq_busy      = irq_busy_q;
   assign irq_id        = id_q;
   assign irq_prio      = prio_q;

endmodule

// File: tb/tb_intp_ctrl_vec.sv
// ---------------------------------------------------------------------------
// tb_intp_ctrl_vec -- self-checking bench for intp_ctrl_vec.
// Each expected (id, prio) is queued when its stimulus is driven. It is popped
// and compared when irq_req is raised.
// ---------------------------------------------------------------------------
module tb_intp_ctrl_vec;

   localparam int N  = 8;
   localparam int IW = 3;
   localparam int PW = 2;
`ifdef INTP_SYNC_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 0;
`endif

   typedef struct {
      logic [IW-1:0] id;
      logic [PW-1:0] prio;
   } exp_t;

   logic            clk = 1'b0;
   logic            rst_n;
   logic [N-1:0]    sig, set, clr, mode, polar, mask;
   logic [N*PW-1:0] prio;
   logic [PW-1:0]   thresh;
   logic            ack, eoi;
   logic [N-1:0]    stat;
   logic            sout, req, busy;
   logic [IW-1:0]   id;
   logic [PW-1:0]   iprio;

   int   errs   = 0;
   int   checks = 0;
   exp_t exp_q[$];

   intp_ctrl_vec #(.SIG_NUM(N), .ID_W(IW), .PRIO_W(PW)) dut (
      .clk(clk), .rst_n(rst_n),
      .intp_sig(sig), .intp_sig_set(set), .intp_sig_clr(clr),
      .intp_sig_mode(mode), .intp_sig_polar(polar), .intp_sig_mask(mask),
      .intp_sig_prio(prio), .prio_thresh(thresh),
      .irq_ack(ack), .irq_eoi(eoi),
      .intp_sig_stat(stat), .intp_sig_out(sout),
      .irq_req(req), .irq_id(id), .irq_prio(iprio), .irq_busy(busy)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_prio(input int src, input logic [PW-1:0] p);
      prio[src*PW +: PW] = p;
   endtask

   task automatic pulse_set(input logic [N-1:0] v);
      set = v;
      tick();
      set = '0;
   endtask

   // Wait (bounded) for irq_req, then pop and compare the expected winner.
   task automatic wait_req(input string name);
      exp_t e;
      int n = 0;
      while (!req && n < 50) begin
         tick();
         n++;
      end
      checks++;
      if (!req) begin
         errs++;
         $display("FAIL %s_timeout: irq_req=%0b expected 1", name, req);
      end else if (exp_q.size() == 0) begin
         errs++;
         $display("FAIL %s_unexpected: irq_id=%0d but no request was expected", name, id);
      end else begin
         e = exp_q.pop_front();
         if (id !== e.id || iprio !== e.prio) begin
            errs++;
            $display("FAIL %s_id: id=%0d prio=%0d expected id=%0d prio=%0d",
                     name, id, iprio, e.id, e.prio);
         end
      end
   endtask

   // Acknowledge and end the current request, checking each handshake step.
   task automatic serve(input string name, input int src);
      ack = 1'b1;
      tick();
      ack = 1'b0;
      checks++;
      if (req !== 1'b0 || busy !== 1'b1 || stat[src] !== 1'b0) begin
         errs++;
         $display("FAIL %s_ack: req=%0b busy=%0b stat=%0b expected 0 1 0",
                  name, req, busy, stat[src]);
      end
      eoi = 1'b1;
      tick();
      eoi = 1'b0;
      checks++;
      if (busy !== 1'b0 || req !== 1'b0) begin
         errs++;
         $display("FAIL %s_eoi: busy=%0b req=%0b expected 0 0", name, busy, req);
      end
   endtask

   task automatic test_reset();
      checks++;
      if (stat !== '0 || sout !== 1'b0 || req !== 1'b0 || busy !== 1'b0 ||
          id !== '0 || iprio !== '0) begin
         errs++;
         $display("FAIL reset: stat=%h out=%0b req=%0b busy=%0b id=%0d prio=%0d expected all 0",
                  stat, sout, req, busy, id, iprio);
      end
   endtask

   task automatic test_edge();
      set_prio(2, 2'd1);
      sig[2] = 1'b1;
      exp_q.push_back('{id: 3'd2, prio: 2'd1});
      repeat (LAT + 1) tick();
      checks++;
      if (stat[2] !== 1'b1 || req !== 1'b0) begin
         errs++;
         $display("FAIL edge_stat: stat2=%0b req=%0b expected 1 0", stat[2], req);
      end
      tick();
      checks++;
      if (req !== 1'b1) begin
         errs++;
         $display("FAIL edge_latency: req=%0b expected 1", req);
      end
      wait_req("edge");
      serve("edge", 2);
      sig[2] = 1'b0;
      repeat (4) tick();
      checks++;
      if (stat[2] !== 1'b0 || req !== 1'b0) begin
         errs++;
         $display("FAIL edge_fall: stat2=%0b req=%0b expected 0 0", stat[2], req);
      end
      set_prio(2, 2'd0);
   endtask

   task automatic test_priority();
      set_prio(1, 2'd2);
      set_prio(5, 2'd3);
      exp_q.push_back('{id: 3'd5, prio: 2'd3});
      exp_q.push_back('{id: 3'd1, prio: 2'd2});
      pulse_set(8'h22);
      wait_req("prio_hi");
      serve("prio_hi", 5);
      wait_req("prio_lo");
      serve("prio_lo", 1);
      set_prio(5, 2'd2);
      exp_q.push_back('{id: 3'd1, prio: 2'd2});
      exp_q.push_back('{id: 3'd5, prio: 2'd2});
      pulse_set(8'h22);
      wait_req("tie_a");
      serve("tie_a", 1);
      wait_req("tie_b");
      serve("tie_b", 5);
      set_prio(1, 2'd0);
      set_prio(5, 2'd0);
   endtask

   task automatic test_level();
      mode[0] = 1'b1;
      set_prio(0, 2'd1);
      sig[0]  = 1'b1;
      exp_q.push_back('{id: 3'd0, prio: 2'd1});
      wait_req("level");
      ack = 1'b1;
      tick();
      ack = 1'b0;
      checks++;
      if (stat[0] !== 1'b0 || busy !== 1'b1) begin
         errs++;
         $display("FAIL level_ack: stat0=%0b busy=%0b expected 0 1", stat[0], busy);
      end
      tick();
      checks++;
      if (stat[0] !== 1'b1) begin
         errs++;
         $display("FAIL level_repend: stat0=%0b expected 1", stat[0]);
      end
      exp_q.push_back('{id: 3'd0, prio: 2'd1});
      eoi = 1'b1;
      tick();
      eoi = 1'b0;
      checks++;
      if (req !== 1'b0 || busy !== 1'b0) begin
         errs++;
         $display("FAIL level_eoi_gap: req=%0b busy=%0b expected 0 0", req, busy);
      end
      tick();
      checks++;
      if (req !== 1'b1) begin
         errs++;
         $display("FAIL level_rereq: req=%0b expected 1", req);
      end
      wait_req("level2");
      sig[0] = 1'b0;
      serve("level2", 0);
      tick();
      checks++;
      if (stat[0] !== 1'b0) begin
         errs++;
         $display("FAIL level_release: stat0=%0b expected 0", stat[0]);
      end
      mode[0] = 1'b0;
      set_prio(0, 2'd0);
   endtask

   task automatic test_withdraw();
      set_prio(3, 2'd1);
      exp_q.push_back('{id: 3'd3, prio: 2'd1});
      pulse_set(8'h08);
      wait_req("wd");
      mask[3] = 1'b1;
      tick();
      checks++;
      if (req !== 1'b0 || stat[3] !== 1'b1 || sout !== 1'b0) begin
         errs++;
         $display("FAIL withdraw: req=%0b stat3=%0b out=%0b expected 0 1 0",
                  req, stat[3], sout);
      end
      tick();
      checks++;
      if (req !== 1'b0 || busy !== 1'b0) begin
         errs++;
         $display("FAIL withdraw_idle: req=%0b busy=%0b expected 0 0", req, busy);
      end
      exp_q.push_back('{id: 3'd3, prio: 2'd1});
      mask[3] = 1'b0;
      wait_req("wd_again");
      serve("wd_again", 3);
      set_prio(3, 2'd0);
   endtask

   task automatic test_setclr_thresh();
      bit seen = 1'b0;
      set_prio(4, 2'd1);
      set[4] = 1'b1;
      clr[4] = 1'b1;
      tick();
      set = '0;
      clr = '0;
      checks++;
      if (stat[4] !== 1'b0) begin
         errs++;
         $display("FAIL setclr: stat4=%0b expected 0", stat[4]);
      end
      thresh = 2'd1;
      pulse_set(8'h10);
      checks++;
      if (stat[4] !== 1'b1 || sout !== 1'b1) begin
         errs++;
         $display("FAIL thresh_stat: stat4=%0b out=%0b expected 1 1", stat[4], sout);
      end
      for (int i = 0; i < 6; i++) begin
         if (req) seen = 1'b1;
         tick();
      end
      checks++;
      if (seen) begin
         errs++;
         $display("FAIL thresh_noreq: req seen=%0b expected 0", seen);
      end
      clr[4] = 1'b1;
      tick();
      clr[4] = 1'b0;
      thresh = 2'd0;
      set_prio(4, 2'd0);
   endtask

   task automatic test_reset_busy();
      set_prio(6, 2'd2);
      exp_q.push_back('{id: 3'd6, prio: 2'd2});
      pulse_set(8'hC0);
      wait_req("rst");
      ack = 1'b1;
      tick();
      ack = 1'b0;
      checks++;
      if (busy !== 1'b1 || stat[7] !== 1'b1) begin
         errs++;
         $display("FAIL rst_pre: busy=%0b stat7=%0b expected 1 1", busy, stat[7]);
      end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (busy !== 1'b0 || req !== 1'b0 || stat !== '0 || sout !== 1'b0) begin
         errs++;
         $display("FAIL rst_busy: busy=%0b req=%0b stat=%h out=%0b expected 0 0 00 0",
                  busy, req, stat, sout);
      end
      tick();
      rst_n = 1'b1;
      tick();
      tick();
      checks++;
      if (busy !== 1'b0 || req !== 1'b0 || stat !== '0) begin
         errs++;
         $display("FAIL rst_after: busy=%0b req=%0b stat=%h expected 0 0 00", busy, req, stat);
      end
      set_prio(6, 2'd0);
   endtask

   initial begin
      rst_n  = 1'b0;
      sig    = '0;
      set    = '0;
      clr    = '0;
      mode   = '0;
      polar  = '1;
      mask   = '0;
      prio   = '0;
      thresh = '0;
      ack    = 1'b0;
      eoi    = 1'b0;
      tick();
      tick();
      test_reset();
      rst_n = 1'b1;
      tick();
      test_edge();
      test_priority();
      test_level();
      test_withdraw();
      test_setclr_thresh();
      test_reset_busy();
      checks++;
      if (exp_q.size() != 0) begin
         errs++;
         $display("FAIL scoreboard_drain: %0d left expected 0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
